// File: rtl/vec_mem_pkg.sv
// Shared types and constants for the pixel-memory vector load path.
// Image geometry, vector word layout, sequencer states and the range check.
package vec_mem_pkg;

  localparam int IMAGE_WIDTH  = 96;
  localparam int IMAGE_HEIGHT = 96;
  localparam int LANES        = 8;
  localparam int VEC_LANES    = 16;

  localparam int PIX_TOTAL  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int VEC_STRIDE = LANES;

  typedef logic [VEC_LANES-1:0][15:0] vec16_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM,
    DONE
  } state_t;

  // Evaluated 20 bits wide so that a huge num_vec can never wrap back into range.
  function automatic logic range_ok(input logic [15:0] base, input logic [15:0] num);
    logic [19:0] span_end;
    span_end = {4'd0, base} + ({4'd0, num} * 20'(VEC_STRIDE));
    return span_end <= 20'(PIX_TOTAL);
  endfunction

endpackage

// File: rtl/vec_load_sequencer_if.sv
// Request/status and output-stream signals of the vector load sequencer.
// Valid/ready: a vector transfers on each rising clk where out_valid && out_ready; while out_valid && !out_ready, out_data and out_idx hold.
interface vec_load_sequencer_if;
  import vec_mem_pkg::*;

  logic        start;
  logic        abort;
  logic [15:0] base_addr;
  logic [15:0] num_vec;
  logic        out_valid;
  logic        out_ready;
  vec16_t      out_data;
  logic [15:0] out_idx;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, abort, base_addr, num_vec, out_ready,
    input  out_valid, out_data, out_idx, busy, done, err
  );

  modport slave (
    input  start, abort, base_addr, num_vec, out_ready,
    output out_valid, out_data, out_idx, busy, done, err
  );

endinterface

// File: rtl/vec_load_sequencer.sv
// Walks a run of consecutive 8-pixel vectors from the pixel memory and streams
// each registered vector downstream at up to one vector per cycle.
module vec_load_sequencer
  import vec_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  vec_load_sequencer_if.slave   bus,
  output logic [15:0]           mem_addr,
  input  vec16_t                mem_rd,
  output state_t                state_dbg
);

  state_t      state, state_n;
  logic [15:0] ptr;
  logic [15:0] remaining;
  logic [15:0] out_idx_q;
  vec16_t      out_data_q;
  logic        out_valid_q, out_valid_n;
  logic        zero_done_q;
  logic        err_q;

  logic        handshake;
  logic        last_vec;
  logic        do_load;
  logic        do_capture;
  logic        do_advance;
  logic        set_err;
  logic        set_zero_done;
  vec16_t      capture_vec;

  assign handshake = out_valid_q & bus.out_ready;
  assign last_vec  = (remaining == 16'd1);

  // Only the real pixel lanes are kept; the upper lanes are forced to zero.
  always_comb begin
    capture_vec = '0;
    for (int k = 0; k < VEC_LANES; k++) begin
      capture_vec[k] = (k < LANES) ? mem_rd[k] : 16'd0;
    end
  end

  always_comb begin
    state_n       = state;
    out_valid_n   = out_valid_q;
    do_load       = 1'b0;
    do_capture    = 1'b0;
    do_advance    = 1'b0;
    set_err       = 1'b0;
    set_zero_done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (!range_ok(bus.base_addr, bus.num_vec)) begin
            set_err = 1'b1;
          end else if (bus.num_vec == 16'd0) begin
            set_zero_done = 1'b1;
          end else begin
            do_load = 1'b1;
            state_n = FETCH;
          end
        end
      end
      FETCH: begin
        do_capture  = 1'b1;
        out_valid_n = 1'b1;
        state_n     = STREAM;
      end
      STREAM: begin
        if (handshake) begin
          if (last_vec) begin
            out_valid_n = 1'b0;
            state_n     = DONE;
          end else begin
            // mem_addr already points at the next vector, so capture it now.
            do_capture = 1'b1;
            do_advance = 1'b1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n     = IDLE;
        out_valid_n = 1'b0;
      end
    endcase
    // Abort outranks start and any pending handshake.
    if (bus.abort) begin
      state_n       = IDLE;
      out_valid_n   = 1'b0;
      do_load       = 1'b0;
      do_capture    = 1'b0;
      do_advance    = 1'b0;
      set_err       = 1'b0;
      set_zero_done = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= 16'd0;
      remaining   <= 16'd0;
      out_idx_q   <= 16'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      zero_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_n;
      zero_done_q <= set_zero_done;
      err_q       <= set_err;
      if (do_load) begin
        ptr       <= bus.base_addr;
        remaining <= bus.num_vec;
        out_idx_q <= 16'd0;
      end
      if (do_capture) begin
        out_data_q <= capture_vec;
        ptr        <= ptr + 16'(VEC_STRIDE);
      end
      if (do_advance) begin
        remaining <= remaining - 16'd1;
        out_idx_q <= out_idx_q + 16'd1;
      end
    end
  end

  assign mem_addr      = ptr;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.busy      = (state == FETCH) || (state == STREAM);
  assign bus.done      = (state == DONE) || zero_done_q;
  assign bus.err       = err_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_vec_load_sequencer.sv
// Bench for vec_load_sequencer: behavioural pixel memory, per-scenario tasks,
// expected vectors built straight from the pixel array.
module tb_vec_load_sequencer;
  import vec_mem_pkg::*;

  localparam int W = 16 + VEC_LANES * 16;
  localparam bit [6:0] STALL_PAT = 7'b1001101;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vec_load_sequencer_if bus();
  logic [15:0] mem_addr;
  vec16_t      mem_rd;
  state_t      state_dbg;

  vec_load_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .state_dbg (state_dbg)
  );

  logic [7:0] pix [PIX_TOTAL];
  vec16_t     junk;

  // Memory model: real pixels in lanes 0..7, noise in the upper lanes.
  always_comb begin
    mem_rd = '0;
    for (int k = 0; k < VEC_LANES; k++) begin
      if (k < LANES) begin
        mem_rd[k] = (int'(mem_addr) + k < PIX_TOTAL) ? {8'h00, pix[int'(mem_addr) + k]} : 16'hbeef;
      end else begin
        mem_rd[k] = junk[k];
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < VEC_LANES; k++) junk[k] = 16'($urandom);
  end

  int vec_cnt = 0;
  int miscmp  = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  int     r_first, r_done_cnt, r_done_cyc, r_last_hs_cyc, r_err_cnt, r_stall_err;
  bit     r_timeout, r_post_abort_valid, r_busy_at_done;
  state_t r_post_abort_state;
  logic [15:0] r_fetch_addr;

  task automatic build_exp(input int base, input int num);
    vec16_t v;
    exp_q.delete();
    for (int i = 0; i < num; i++) begin
      v = '0;
      for (int k = 0; k < LANES; k++) v[k] = {8'h00, pix[base + i * LANES + k]};
      exp_q.push_back({16'(i), v});
    end
  endtask

  // Driver: issues one start, plays the consumer, records what it saw.
  task automatic run_txn(input logic [15:0] base, input logic [15:0] num,
                         input int ready_mode, input int abort_after, input int extra_start_cyc);
    int hs_cnt, abort_cyc, rpos;
    bit fin, aborted, prev_stall;
    vec16_t prev_data;
    logic [15:0] prev_idx;
    obs_q.delete();
    r_first = -1; r_done_cnt = 0; r_done_cyc = -1; r_last_hs_cyc = -1; r_err_cnt = 0;
    r_stall_err = 0; r_timeout = 0; r_post_abort_valid = 0; r_post_abort_state = IDLE;
    r_busy_at_done = 0; r_fetch_addr = '0;
    hs_cnt = 0; abort_cyc = -1; rpos = 0; fin = 0; aborted = 0; prev_stall = 0;
    prev_data = '0; prev_idx = '0;
    @(negedge clk);
    bus.base_addr = base;
    bus.num_vec   = num;
    bus.start     = 1'b1;
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (cyc == 1) r_fetch_addr = mem_addr;
      if (bus.done) begin r_done_cnt++; r_done_cyc = cyc; r_busy_at_done = bus.busy; end
      if (bus.err) r_err_cnt++;
      if (bus.out_valid && r_first < 0) r_first = cyc;
      if (prev_stall && (bus.out_data !== prev_data || bus.out_idx !== prev_idx)) r_stall_err++;
      if (aborted && cyc == abort_cyc + 1) begin
        r_post_abort_valid = bus.out_valid;
        r_post_abort_state = state_dbg;
      end
      if (cyc == extra_start_cyc) begin
        bus.start = 1'b1; bus.base_addr = 16'd512; bus.num_vec = 16'd2;
      end
      if (abort_after >= 0 && !aborted && hs_cnt == abort_after) begin
        bus.abort = 1'b1; aborted = 1; abort_cyc = cyc;
      end
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: begin
          bus.out_ready = bus.out_valid ? STALL_PAT[6 - (rpos % 7)] : 1'b0;
          if (bus.out_valid) rpos++;
        end
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (bus.out_valid && bus.out_ready && !bus.abort) begin
        obs_q.push_back({bus.out_idx, bus.out_data});
        hs_cnt++;
        r_last_hs_cyc = cyc;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_idx   = bus.out_idx;
      if (cyc >= 3 && !bus.busy && !bus.done && !bus.abort && (!aborted || cyc > abort_cyc + 2)) fin = 1;
    end
    if (!fin) r_timeout = 1;
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.abort = 0; bus.base_addr = 0; bus.num_vec = 0; bus.out_ready = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if ({mem_addr, bus.out_valid, bus.out_idx, bus.busy, bus.done, bus.err} !== '0 || state_dbg !== IDLE) begin
      miscmp++;
      $display("FAIL reset_ctrl: got addr=%h valid=%b idx=%h busy=%b done=%b err=%b state=%0d, expected all zero/IDLE",
               mem_addr, bus.out_valid, bus.out_idx, bus.busy, bus.done, bus.err, state_dbg);
    end
    vec_cnt++;
    if (bus.out_data !== '0) begin
      miscmp++; $display("FAIL reset_data: got %h expected 0", bus.out_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < PIX_TOTAL; i++) pix[i] = 8'(i % 256);
    build_exp(0, 3);
    run_txn(16'd0, 16'd3, 0, -1, -1);
    vec_cnt++; if (r_timeout) begin miscmp++; $display("FAIL basic_timeout: got timeout expected completion"); end
    vec_cnt++; if (r_fetch_addr !== 16'd0) begin miscmp++; $display("FAIL basic_addr: got %0d expected 0", r_fetch_addr); end
    vec_cnt++; if (r_first != 2) begin miscmp++; $display("FAIL basic_latency: got %0d expected 2", r_first); end
    vec_cnt++; if (obs_q.size() != exp_q.size()) begin miscmp++; $display("FAIL basic_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vec_cnt++;
      if (obs_q[i] !== exp_q[i]) begin miscmp++; $display("FAIL basic_vec%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    vec_cnt++; if (r_done_cnt != 1 || r_done_cyc - r_last_hs_cyc != 1) begin
      miscmp++; $display("FAIL basic_done: got count=%0d gap=%0d expected 1/1", r_done_cnt, r_done_cyc - r_last_hs_cyc);
    end
    vec_cnt++; if (r_busy_at_done !== 1'b0) begin miscmp++; $display("FAIL basic_busy_done: got %b expected 0", r_busy_at_done); end
  endtask

  task automatic test_boundary();
    build_exp(9208, 1);
    run_txn(16'd9208, 16'd1, 0, -1, -1);
    vec_cnt++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      miscmp++; $display("FAIL edge_last: got n=%0d v=%h expected n=1 v=%h", obs_q.size(), obs_q.size() ? obs_q[0] : '0, exp_q[0]);
    end
    vec_cnt++; if (r_done_cnt != 1 || r_err_cnt != 0) begin miscmp++; $display("FAIL edge_last_status: got done=%0d err=%0d expected 1/0", r_done_cnt, r_err_cnt); end
    run_txn(16'd9209, 16'd1, 0, -1, -1);
    vec_cnt++; if (r_err_cnt != 1 || r_first != -1 || r_done_cnt != 0) begin
      miscmp++; $display("FAIL edge_over: got err=%0d first_valid=%0d done=%0d expected 1/-1/0", r_err_cnt, r_first, r_done_cnt);
    end
    build_exp(9200, 2);
    run_txn(16'd9200, 16'd2, 0, -1, -1);
    vec_cnt++; if (obs_q.size() != 2 || obs_q[1] !== exp_q[1]) begin miscmp++; $display("FAIL edge_two: got n=%0d expected 2 matching vectors", obs_q.size()); end
    run_txn(16'd0, 16'd2000, 0, -1, -1);
    vec_cnt++; if (r_err_cnt != 1 || r_first != -1) begin miscmp++; $display("FAIL edge_long: got err=%0d first_valid=%0d expected 1/-1", r_err_cnt, r_first); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < PIX_TOTAL; i++) pix[i] = 8'($urandom);
    build_exp(333, 4);
    run_txn(16'd333, 16'd4, 1, -1, -1);
    vec_cnt++; if (r_stall_err != 0) begin miscmp++; $display("FAIL stall_hold: got %0d changes expected 0", r_stall_err); end
    vec_cnt++; if (obs_q.size() != 4) begin miscmp++; $display("FAIL stall_count: got %0d expected 4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vec_cnt++;
      if (obs_q[i] !== exp_q[i]) begin miscmp++; $display("FAIL stall_vec%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    vec_cnt++; if (r_done_cnt != 1 || r_timeout) begin miscmp++; $display("FAIL stall_done: got done=%0d timeout=%0b expected 1/0", r_done_cnt, r_timeout); end
  endtask

  task automatic test_zero_and_ignore();
    run_txn(16'd100, 16'd0, 0, -1, -1);
    vec_cnt++; if (r_done_cnt != 1 || r_done_cyc != 1 || r_first != -1 || obs_q.size() != 0) begin
      miscmp++; $display("FAIL zero_len: got done=%0d at %0d first_valid=%0d n=%0d expected 1 at 1, -1, 0",
                         r_done_cnt, r_done_cyc, r_first, obs_q.size());
    end
    build_exp(200, 6);
    run_txn(16'd200, 16'd6, 0, -1, 4);
    vec_cnt++; if (obs_q.size() != 6 || r_done_cnt != 1) begin miscmp++; $display("FAIL ignore_count: got n=%0d done=%0d expected 6/1", obs_q.size(), r_done_cnt); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vec_cnt++;
      if (obs_q[i] !== exp_q[i]) begin miscmp++; $display("FAIL ignore_vec%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    build_exp(300, 5);
    run_txn(16'd300, 16'd5, 0, 2, -1);
    vec_cnt++; if (r_post_abort_valid !== 1'b0 || r_post_abort_state !== IDLE) begin
      miscmp++; $display("FAIL abort_stop: got valid=%b state=%0d expected 0/IDLE", r_post_abort_valid, r_post_abort_state);
    end
    vec_cnt++; if (r_done_cnt != 0 || obs_q.size() != 2) begin miscmp++; $display("FAIL abort_count: got done=%0d n=%0d expected 0/2", r_done_cnt, obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 2; i++) begin
      vec_cnt++;
      if (obs_q[i] !== exp_q[i]) begin miscmp++; $display("FAIL abort_vec%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    build_exp(64, 3);
    run_txn(16'd64, 16'd3, 0, -1, -1);
    vec_cnt++; if (r_fetch_addr !== 16'd64) begin miscmp++; $display("FAIL restart_addr: got %0d expected 64", r_fetch_addr); end
    vec_cnt++; if (obs_q.size() != 3 || obs_q[0] !== exp_q[0] || obs_q[2] !== exp_q[2]) begin
      miscmp++; $display("FAIL restart_vecs: got n=%0d first=%h expected 3 first=%h", obs_q.size(), obs_q.size() ? obs_q[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_async_reset();
    logic seen_stream;
    @(negedge clk);
    bus.base_addr = 16'd16; bus.num_vec = 16'd10; bus.start = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    seen_stream = bus.out_valid && (state_dbg == STREAM);
    vec_cnt++; if (!seen_stream) begin miscmp++; $display("FAIL areset_setup: got valid=%b state=%0d expected 1/STREAM", bus.out_valid, state_dbg); end
    #2 rst = 1'b1;
    #1;
    vec_cnt++;
    if ({mem_addr, bus.out_valid, bus.out_idx, bus.busy, bus.done, bus.err} !== '0 || bus.out_data !== '0 || state_dbg !== IDLE) begin
      miscmp++; $display("FAIL areset_clear: got addr=%h valid=%b idx=%h busy=%b data=%h expected zeros",
                         mem_addr, bus.out_valid, bus.out_idx, bus.busy, bus.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    build_exp(40, 3);
    run_txn(16'd40, 16'd3, 2, -1, -1);
    vec_cnt++; if (obs_q.size() != 3 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1] || obs_q[2] !== exp_q[2]) begin
      miscmp++; $display("FAIL areset_after: got n=%0d expected 3 matching vectors", obs_q.size());
    end
  endtask

  task automatic test_random();
    int num, base;
    bit legal;
    for (int t = 0; t < 15; t++) begin
      num = $urandom_range(1, 12);
      if (t % 5 == 4) base = PIX_TOTAL - num * LANES + $urandom_range(1, 8);
      else base = $urandom_range(0, PIX_TOTAL - num * LANES);
      legal = (base + num * LANES) <= PIX_TOTAL;
      if (legal) build_exp(base, num); else exp_q.delete();
      run_txn(16'(base), 16'(num), 2, -1, -1);
      vec_cnt++;
      if (r_timeout || r_stall_err != 0 || r_err_cnt != (legal ? 0 : 1) || r_done_cnt != (legal ? 1 : 0)) begin
        miscmp++; $display("FAIL rand%0d_status: got timeout=%0b stall=%0d err=%0d done=%0d legal=%0b",
                           t, r_timeout, r_stall_err, r_err_cnt, r_done_cnt, legal);
      end
      vec_cnt++;
      if (obs_q.size() != exp_q.size()) begin miscmp++; $display("FAIL rand%0d_count: got %0d expected %0d", t, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        vec_cnt++;
        if (obs_q[i] !== exp_q[i]) begin miscmp++; $display("FAIL rand%0d_vec%0d: got %h expected %h", t, i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_stall();
    test_zero_and_ignore();
    test_abort();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
